// File: rtl/cfo_corrector.sv
// cfo_corrector: carrier-frequency-offset derotator for a streaming complex
// sample path. Every valid input beat is multiplied by exp(-j*phi). phi
// comes from a phase accumulator that advances by the active CFO word on
// every rotated beat. The LUT address is the top LUT_AW bits of phi.
//
// Fixed latency of 4 cycles in every mode (p0 -> p1 -> p2 -> p3 = output).
//
// Ports
//   clk_i             single clock, rising edge
//   reset_i           synchronous active-high reset
//   s_axis_in_tdata   input sample {imag, real}, signed halves of IN_DW/2
//   s_axis_in_tvalid  input beat valid (no back-pressure)
//   s_axis_in_tuser   frame-start marker, qualified by tvalid
//   cfo_norm_i        signed CFO word, CFO_hz/fs * 2^PHASE_DW
//   cfo_valid_i       single-cycle load strobe for cfo_norm_i
//   mode_i            0 bypass, 1 immediate, 2 apply-on-frame-start, 3 = 0
//   phase_clear_i     zero the phase accumulator (beat in this cycle uses 0)
//   m_axis_out_tdata  corrected sample {imag, real}, signed halves of OUT_DW/2
//   m_axis_out_tvalid output beat valid
//   m_axis_out_tuser  delayed s_axis_in_tuser
//   cfo_active_o      CFO word currently applied to the accumulator
//   pending_o         a loaded CFO word waits for the next frame start
module cfo_corrector #(
  parameter int IN_DW    = 32,
  parameter int OUT_DW   = 32,
  parameter int PHASE_DW = 20,
  parameter int LUT_AW   = 10
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [IN_DW-1:0]    s_axis_in_tdata,
  input  logic                s_axis_in_tvalid,
  input  logic                s_axis_in_tuser,
  input  logic [PHASE_DW-1:0] cfo_norm_i,
  input  logic                cfo_valid_i,
  input  logic [1:0]          mode_i,
  input  logic                phase_clear_i,
  output logic [OUT_DW-1:0]   m_axis_out_tdata,
  output logic                m_axis_out_tvalid,
  output logic                m_axis_out_tuser,
  output logic [PHASE_DW-1:0] cfo_active_o,
  output logic                pending_o
);

  localparam int IW     = IN_DW / 2;
  localparam int OW     = OUT_DW / 2;
  localparam int LUT_N  = 1 << LUT_AW;
  localparam int PROD_W = IW + 16;
  // Sum of two products needs one bit more; never narrower than OW+1 so the
  // saturation bounds are representable.
  localparam int SUM_W  = (IW + 17 > OW + 1) ? IW + 17 : OW + 1;
  localparam int EXT_W  = (IW > OW) ? IW : OW;

  localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(16384);
  localparam logic signed [SUM_W-1:0] SAT_MAX  = {{(SUM_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN  = {{(SUM_W-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_IMMED  = 2'd1,
    MODE_FRAME  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  // Round half-up from Q15 back to sample scale.
  function automatic logic signed [SUM_W-1:0] round_q15(input logic signed [SUM_W-1:0] v);
    return (v + RND_HALF) >>> 15;
  endfunction

  // Clamp to the signed OW-bit range.
  function automatic logic signed [OW-1:0] sat_ow(input logic signed [SUM_W-1:0] v);
    logic signed [OW-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[OW-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[OW-1:0];
    else                  r = v[OW-1:0];
    return r;
  endfunction

  // Bypass path: sign-extend or truncate one component to OW bits.
  function automatic logic signed [OW-1:0] fit_ow(input logic signed [IW-1:0] x);
    logic signed [EXT_W-1:0] t;
    t = EXT_W'(x);
    return t[OW-1:0];
  endfunction

  // Full-wave cos/sin table, built at elaboration time. Round to nearest,
  // ties away from zero.
  logic signed [15:0] cos_lut [LUT_N];
  logic signed [15:0] sin_lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam real ANG   = 6.283185307179586 * real'(k) / real'(LUT_N);
    localparam real COS_R = 32767.0 * $cos(ANG);
    localparam real SIN_R = 32767.0 * $sin(ANG);
    localparam int  COS_I = (COS_R >= 0.0) ? $rtoi(COS_R + 0.5) : -$rtoi(0.5 - COS_R);
    localparam int  SIN_I = (SIN_R >= 0.0) ? $rtoi(SIN_R + 0.5) : -$rtoi(0.5 - SIN_R);
    assign cos_lut[k] = 16'(COS_I);
    assign sin_lut[k] = 16'(SIN_I);
  end

  // Phase / CFO control state
  logic [PHASE_DW-1:0] phase_acc;
  logic [PHASE_DW-1:0] cfo_active;
  logic [PHASE_DW-1:0] cfo_pend;
  logic                pending;

  mode_e               mode;
  logic                is_bypass;
  logic                is_frame;
  logic                frame_start;
  logic                take_pend;
  logic                zero_phi;
  logic [LUT_AW-1:0]   addr_nxt;
  logic [PHASE_DW-1:0] phase_inc;
  logic [PHASE_DW-1:0] phase_nxt;

  always_comb begin
    mode        = mode_e'(mode_i);
    is_bypass   = (mode == MODE_BYPASS) || (mode == MODE_RSVD);
    is_frame    = (mode == MODE_FRAME);
    frame_start = is_frame && s_axis_in_tvalid && s_axis_in_tuser;
    take_pend   = frame_start && pending;
    zero_phi    = phase_clear_i || frame_start;
    addr_nxt    = zero_phi ? '0 : phase_acc[PHASE_DW-1 -: LUT_AW];
    // A frame start that promotes the pending word advances with the new word,
    // so the beat after the frame start is already rotated by it.
    phase_inc   = take_pend ? cfo_pend : cfo_active;
    phase_nxt   = phase_acc;
    if (!is_bypass && s_axis_in_tvalid) begin
      // Modular add: wrap-around is the intended phase behaviour.
      phase_nxt = (zero_phi ? '0 : phase_acc) + phase_inc;
    end else if (phase_clear_i) begin
      phase_nxt = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_acc  <= '0;
      cfo_active <= '0;
      cfo_pend   <= '0;
      pending    <= 1'b0;
    end else begin
      phase_acc <= phase_nxt;
      if (mode == MODE_IMMED && cfo_valid_i) begin
        cfo_active <= cfo_norm_i;
      end else if (take_pend) begin
        cfo_active <= cfo_pend;
      end
      // A load coinciding with a frame start stays pending for the next one.
      if (!is_frame) begin
        pending <= 1'b0;
      end else if (cfo_valid_i) begin
        pending  <= 1'b1;
        cfo_pend <= cfo_norm_i;
      end else if (frame_start) begin
        pending <= 1'b0;
      end
    end
  end

  assign cfo_active_o = cfo_active;
  assign pending_o    = pending;

  // ---- p0: capture beat and its LUT address ----
  logic                    vld_p0, tuser_p0, byp_p0;
  logic signed [IW-1:0]    re_p0, im_p0;
  logic [LUT_AW-1:0]       addr_p0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p0   <= 1'b0;
      tuser_p0 <= 1'b0;
    end else begin
      vld_p0   <= s_axis_in_tvalid;
      tuser_p0 <= s_axis_in_tvalid && s_axis_in_tuser;
    end
    byp_p0  <= is_bypass;
    re_p0   <= s_axis_in_tdata[IW-1:0];
    im_p0   <= s_axis_in_tdata[2*IW-1:IW];
    addr_p0 <= addr_nxt;
  end

  // ---- p1: table lookup ----
  logic                    vld_p1, tuser_p1, byp_p1;
  logic signed [IW-1:0]    re_p1, im_p1;
  logic signed [15:0]      cos_p1, sin_p1;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p1   <= 1'b0;
      tuser_p1 <= 1'b0;
    end else begin
      vld_p1   <= vld_p0;
      tuser_p1 <= tuser_p0;
    end
    byp_p1 <= byp_p0;
    re_p1  <= re_p0;
    im_p1  <= im_p0;
    cos_p1 <= cos_lut[addr_p0];
    sin_p1 <= sin_lut[addr_p0];
  end

  // ---- p2: full-precision products ----
  logic                    vld_p2, tuser_p2, byp_p2;
  logic signed [IW-1:0]    re_p2, im_p2;
  logic signed [PROD_W-1:0] prod_rc_p2, prod_is_p2, prod_ic_p2, prod_rs_p2;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p2   <= 1'b0;
      tuser_p2 <= 1'b0;
    end else begin
      vld_p2   <= vld_p1;
      tuser_p2 <= tuser_p1;
    end
    byp_p2     <= byp_p1;
    re_p2      <= re_p1;
    im_p2      <= im_p1;
    prod_rc_p2 <= PROD_W'(re_p1) * PROD_W'(cos_p1);
    prod_is_p2 <= PROD_W'(im_p1) * PROD_W'(sin_p1);
    prod_ic_p2 <= PROD_W'(im_p1) * PROD_W'(cos_p1);
    prod_rs_p2 <= PROD_W'(re_p1) * PROD_W'(sin_p1);
  end

  // ---- p3: sum, round, saturate -> output register ----
  logic signed [SUM_W-1:0] sum_re, sum_im;
  logic [OUT_DW-1:0]       data_nxt;

  always_comb begin
    sum_re   = SUM_W'(prod_rc_p2) + SUM_W'(prod_is_p2);
    sum_im   = SUM_W'(prod_ic_p2) - SUM_W'(prod_rs_p2);
    data_nxt = byp_p2 ? {fit_ow(im_p2), fit_ow(re_p2)}
                      : {sat_ow(round_q15(sum_im)), sat_ow(round_q15(sum_re))};
  end

  logic                    vld_p3, tuser_p3;
  logic [OUT_DW-1:0]       data_p3;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p3   <= 1'b0;
      tuser_p3 <= 1'b0;
      data_p3  <= '0;
    end else begin
      vld_p3   <= vld_p2;
      tuser_p3 <= tuser_p2;
      data_p3  <= data_nxt;
    end
  end

  assign m_axis_out_tdata  = data_p3;
  assign m_axis_out_tvalid = vld_p3;
  assign m_axis_out_tuser  = tuser_p3;

endmodule

// File: tb/tb_cfo_corrector.sv
// Directed testbench for cfo_corrector with default parameters.
module tb_cfo_corrector;
  localparam int IN_DW    = 32;
  localparam int OUT_DW   = 32;
  localparam int PHASE_DW = 20;
  localparam int LUT_AW   = 10;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic [IN_DW-1:0]    s_axis_in_tdata;
  logic                s_axis_in_tvalid;
  logic                s_axis_in_tuser;
  logic [PHASE_DW-1:0] cfo_norm_i;
  logic                cfo_valid_i;
  logic [1:0]          mode_i;
  logic                phase_clear_i;
  logic [OUT_DW-1:0]   m_axis_out_tdata;
  logic                m_axis_out_tvalid;
  logic                m_axis_out_tuser;
  logic [PHASE_DW-1:0] cfo_active_o;
  logic                pending_o;

  cfo_corrector #(
    .IN_DW(IN_DW), .OUT_DW(OUT_DW), .PHASE_DW(PHASE_DW), .LUT_AW(LUT_AW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tvalid(s_axis_in_tvalid),
    .s_axis_in_tuser(s_axis_in_tuser), .cfo_norm_i(cfo_norm_i),
    .cfo_valid_i(cfo_valid_i), .mode_i(mode_i), .phase_clear_i(phase_clear_i),
    .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tvalid(m_axis_out_tvalid),
    .m_axis_out_tuser(m_axis_out_tuser), .cfo_active_o(cfo_active_o),
    .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [PHASE_DW-1:0] QUARTER = 20'h40000;  // 2^(PHASE_DW-2)
  localparam logic [PHASE_DW-1:0] EIGHTH  = 20'h20000;  // 2^(PHASE_DW-3)

  // Expected sample words {im, re}
  localparam logic [31:0] D_P0   = 32'h0000_4000;  // (16384, 0)
  localparam logic [31:0] D_P90  = 32'hC001_0000;  // (0, -16383)
  localparam logic [31:0] D_P180 = 32'h0000_C001;  // (-16383, 0)
  localparam logic [31:0] D_P270 = 32'h4000_0000;  // (0, 16384)

  int checks   = 0;
  int failures = 0;

  logic [31:0] in_data [8];
  logic        in_user [8];
  logic        in_clr  [8];
  logic [1:0]  in_mode [8];
  logic [31:0] cap_data [8];
  logic        cap_user [8];
  logic        cap_vld  [8];
  logic        early_vld;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    s_axis_in_tvalid = 1'b0;
    s_axis_in_tuser  = 1'b0;
    s_axis_in_tdata  = '0;
    cfo_valid_i      = 1'b0;
    phase_clear_i    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic load_cfo(input logic [PHASE_DW-1:0] w);
    cfo_norm_i  = w;
    cfo_valid_i = 1'b1;
    tick();
    cfo_valid_i = 1'b0;
  endtask

  // Drive n back-to-back beats from the in_* tables and capture whatever
  // appears on the output exactly four cycles after each one.
  task automatic run_stream(input int n);
    early_vld = 1'b0;
    for (int t = 0; t < n + 3; t++) begin
      if (t < n) begin
        s_axis_in_tvalid = 1'b1;
        s_axis_in_tdata  = in_data[t];
        s_axis_in_tuser  = in_user[t];
        phase_clear_i    = in_clr[t];
        mode_i           = in_mode[t];
      end else begin
        idle_inputs();
      end
      tick();
      if (t < 3) begin
        early_vld = early_vld | m_axis_out_tvalid;
      end else begin
        cap_vld[t-3]  = m_axis_out_tvalid;
        cap_data[t-3] = m_axis_out_tdata;
        cap_user[t-3] = m_axis_out_tuser;
      end
    end
  endtask

  task automatic set_beats(input logic [31:0] d, input logic [1:0] m);
    for (int i = 0; i < 8; i++) begin
      in_data[i] = d;
      in_user[i] = 1'b0;
      in_clr[i]  = 1'b0;
      in_mode[i] = m;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    s_axis_in_tvalid = 1'b1;
    s_axis_in_tdata  = 32'h1234_5678;
    s_axis_in_tuser  = 1'b1;
    cfo_norm_i = QUARTER;
    cfo_valid_i = 1'b1;
    mode_i = 2'd1;
    tick();
    tick();
    tick();
    checks++;
    if (m_axis_out_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_out_tvalid); end
    checks++;
    if (m_axis_out_tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata: got %h expected 00000000", m_axis_out_tdata); end
    checks++;
    if (m_axis_out_tuser !== 1'b0) begin failures++; $display("FAIL reset_tuser: got %b expected 0", m_axis_out_tuser); end
    checks++;
    if (cfo_active_o !== '0) begin failures++; $display("FAIL reset_cfo_active: got %h expected 0", cfo_active_o); end
    checks++;
    if (pending_o !== 1'b0) begin failures++; $display("FAIL reset_pending: got %b expected 0", pending_o); end
    reset_i = 1'b0;
    idle_inputs();
  endtask

  task automatic test_bypass();
    do_reset();
    set_beats(D_P0, 2'd0);
    in_user[0] = 1'b1;
    in_data[1] = 32'h8001_7FFF;
    in_mode[1] = 2'd3;
    run_stream(2);
    checks++;
    if (early_vld !== 1'b0) begin failures++; $display("FAIL bypass_early_valid: got %b expected 0", early_vld); end
    checks++;
    if (cap_vld[0] !== 1'b1 || cap_data[0] !== D_P0 || cap_user[0] !== 1'b1)
      begin failures++; $display("FAIL bypass_beat0: got vld=%b data=%h user=%b expected vld=1 data=%h user=1", cap_vld[0], cap_data[0], cap_user[0], D_P0); end
    checks++;
    if (cap_vld[1] !== 1'b1 || cap_data[1] !== 32'h8001_7FFF || cap_user[1] !== 1'b0)
      begin failures++; $display("FAIL bypass_mode3: got vld=%b data=%h user=%b expected vld=1 data=80017fff user=0", cap_vld[1], cap_data[1], cap_user[1]); end
  endtask

  task automatic test_immediate();
    logic [31:0] exp_d [4];
    exp_d = '{D_P0, D_P90, D_P180, D_P270};
    do_reset();
    mode_i = 2'd1;
    load_cfo(QUARTER);
    checks++;
    if (cfo_active_o !== QUARTER) begin failures++; $display("FAIL imm_cfo_active: got %h expected %h", cfo_active_o, QUARTER); end
    set_beats(D_P0, 2'd1);
    run_stream(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_vld[i] !== 1'b1 || cap_data[i] !== exp_d[i])
        begin failures++; $display("FAIL imm_beat%0d: got vld=%b data=%h expected vld=1 data=%h", i, cap_vld[i], cap_data[i], exp_d[i]); end
    end
  endtask

  task automatic test_bypass_hold();
    logic [31:0] exp_d [4];
    exp_d = '{D_P0, D_P0, D_P0, D_P90};
    do_reset();
    mode_i = 2'd1;
    load_cfo(QUARTER);
    set_beats(D_P0, 2'd1);
    in_mode[1] = 2'd0;
    in_mode[2] = 2'd0;
    run_stream(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_vld[i] !== 1'b1 || cap_data[i] !== exp_d[i])
        begin failures++; $display("FAIL hold_beat%0d: got vld=%b data=%h expected vld=1 data=%h", i, cap_vld[i], cap_data[i], exp_d[i]); end
    end
  endtask

  task automatic test_frame();
    logic [31:0] exp_d [5];
    exp_d = '{D_P0, D_P0, D_P0, D_P90, D_P180};
    do_reset();
    mode_i = 2'd2;
    load_cfo(QUARTER);
    checks++;
    if (pending_o !== 1'b1 || cfo_active_o !== '0)
      begin failures++; $display("FAIL frame_pending_set: got pending=%b active=%h expected pending=1 active=0", pending_o, cfo_active_o); end
    set_beats(D_P0, 2'd2);
    in_user[2] = 1'b1;
    run_stream(5);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap_vld[i] !== 1'b1 || cap_data[i] !== exp_d[i] || cap_user[i] !== (i == 2))
        begin failures++; $display("FAIL frame_beat%0d: got vld=%b data=%h user=%b expected vld=1 data=%h user=%b", i, cap_vld[i], cap_data[i], cap_user[i], exp_d[i], (i == 2)); end
    end
    checks++;
    if (pending_o !== 1'b0 || cfo_active_o !== QUARTER)
      begin failures++; $display("FAIL frame_applied: got pending=%b active=%h expected pending=0 active=%h", pending_o, cfo_active_o, QUARTER); end
    // Load coinciding with a frame-start beat stays pending.
    mode_i = 2'd2;
    s_axis_in_tvalid = 1'b1;
    s_axis_in_tuser  = 1'b1;
    s_axis_in_tdata  = D_P0;
    cfo_norm_i  = EIGHTH;
    cfo_valid_i = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (pending_o !== 1'b1 || cfo_active_o !== QUARTER)
      begin failures++; $display("FAIL frame_same_cycle: got pending=%b active=%h expected pending=1 active=%h", pending_o, cfo_active_o, QUARTER); end
    // Leaving mode 2 discards the pending word.
    mode_i = 2'd1;
    tick();
    mode_i = 2'd2;
    tick();
    checks++;
    if (pending_o !== 1'b0 || cfo_active_o !== QUARTER)
      begin failures++; $display("FAIL frame_discard: got pending=%b active=%h expected pending=0 active=%h", pending_o, cfo_active_o, QUARTER); end
  endtask

  task automatic test_wrap();
    do_reset();
    mode_i = 2'd1;
    load_cfo('1);
    set_beats(D_P0, 2'd1);
    run_stream(2);
    checks++;
    if (cap_vld[0] !== 1'b1 || cap_data[0] !== D_P0)
      begin failures++; $display("FAIL wrap_beat0: got vld=%b data=%h expected vld=1 data=%h", cap_vld[0], cap_data[0], D_P0); end
    // addr 1023: cos=32766, sin=-201 -> re=16383, im=101
    checks++;
    if (cap_vld[1] !== 1'b1 || cap_data[1] !== 32'h0065_3FFF)
      begin failures++; $display("FAIL wrap_beat1: got vld=%b data=%h expected vld=1 data=00653fff", cap_vld[1], cap_data[1]); end
  endtask

  task automatic test_saturate();
    do_reset();
    mode_i = 2'd1;
    load_cfo(EIGHTH);
    set_beats(D_P0, 2'd1);
    in_data[1] = 32'h8000_8000;
    run_stream(2);
    checks++;
    if (cap_vld[0] !== 1'b1 || cap_data[0] !== D_P0)
      begin failures++; $display("FAIL sat_beat0: got vld=%b data=%h expected vld=1 data=%h", cap_vld[0], cap_data[0], D_P0); end
    checks++;
    if (cap_vld[1] !== 1'b1 || cap_data[1] !== 32'h0000_8000)
      begin failures++; $display("FAIL sat_beat1: got vld=%b data=%h expected vld=1 data=00008000", cap_vld[1], cap_data[1]); end
  endtask

  task automatic test_phase_clear();
    logic [31:0] exp_d [4];
    exp_d = '{D_P0, D_P90, D_P0, D_P90};
    do_reset();
    mode_i = 2'd1;
    load_cfo(QUARTER);
    set_beats(D_P0, 2'd1);
    in_clr[2] = 1'b1;
    run_stream(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_vld[i] !== 1'b1 || cap_data[i] !== exp_d[i])
        begin failures++; $display("FAIL clear_beat%0d: got vld=%b data=%h expected vld=1 data=%h", i, cap_vld[i], cap_data[i], exp_d[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    logic any_vld;
    do_reset();
    mode_i = 2'd1;
    load_cfo(QUARTER);
    mode_i = 2'd2;
    load_cfo(EIGHTH);
    for (int i = 0; i < 3; i++) begin
      s_axis_in_tvalid = 1'b1;
      s_axis_in_tdata  = D_P0;
      tick();
    end
    idle_inputs();
    reset_i = 1'b1;
    tick();
    checks++;
    if (m_axis_out_tvalid !== 1'b0) begin failures++; $display("FAIL midrst_next_cycle: got tvalid=%b expected 0", m_axis_out_tvalid); end
    reset_i = 1'b0;
    any_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      any_vld = any_vld | m_axis_out_tvalid;
    end
    checks++;
    if (any_vld !== 1'b0) begin failures++; $display("FAIL midrst_drained: got tvalid seen=%b expected 0", any_vld); end
    checks++;
    if (cfo_active_o !== '0 || pending_o !== 1'b0)
      begin failures++; $display("FAIL midrst_state: got active=%h pending=%b expected active=0 pending=0", cfo_active_o, pending_o); end
  endtask

  initial begin
    reset_i = 1'b1;
    mode_i = 2'd0;
    cfo_norm_i = '0;
    idle_inputs();
    test_reset();
    test_bypass();
    test_immediate();
    test_bypass_hold();
    test_frame();
    test_wrap();
    test_saturate();
    test_phase_clear();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
